inst_mem_fetch_unit: RTL and testbench
======================================

Name: inst_mem_fetch_unit

Overview:
Parametrised, byte-addressed, little-endian instruction memory for the single-cycle RISC-V core's fetch path. It replaces the fixed 16-byte combinational ROM with a depth-configurable RAM. It adds a byte-write program loader port, a valid/ready fetch request and response handshake with one-cycle registered latency, and alignment and range fault detection. A fetch counter is provided for debug.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; must be a power of two and at least 4
ADDR_W, 64, width of the fetch and load address ports
CNT_W, 32, width of Fetch_Count

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
Load_En  input  1  byte write strobe for the program loader
Load_Addr  input  ADDR_W  byte address of the loader write
Load_Data  input  8  byte written to Array[Load_Addr]
Req_Valid  input  1  fetch request valid
Req_Ready  output  1  fetch request accepted when Req_Valid and Req_Ready are both high
Inst_Addr  input  ADDR_W  fetch byte address
Rsp_Valid  output  1  response holds a valid instruction or fault
Rsp_Ready  input  1  consumer accepts the response
Instruction  output  32  {Array[A+3],Array[A+2],Array[A+1],Array[A]}
Fault  output  1  the response is a fault (misaligned or out of range)
Fetch_Count  output  CNT_W  number of accepted fetch requests

Behaviour:
- Reset (asynchronous assert, synchronous release): Rsp_Valid=0, Fault=0, Instruction=32'h00000013 (NOP), Fetch_Count=0, FSM state=EMPTY. Memory contents are not reset.
- Req_Ready = (state==EMPTY || Rsp_Ready) && !Load_En. Fetch is stalled while the loader is writing.
- Loader: when Load_En is high and Load_Addr < DEPTH_BYTES, Array[Load_Addr[log2(DEPTH_BYTES)-1:0]] <= Load_Data. Out-of-range loader writes are dropped silently.
- FSM states:
  - EMPTY: on an accepted request, go to FULL; otherwise stay.
  - FULL: Rsp_Valid=1. If Rsp_Ready is low, hold all response outputs stable. If Rsp_Ready is high and a new request is accepted in the same cycle, stay in FULL with the new response. If Rsp_Ready is high and no request is accepted, go to EMPTY.
- Latency: the response appears on the cycle after acceptance. Back-to-back requests sustain one instruction per cycle while Rsp_Ready stays high.
- Fault detection on an accepted request:
  - Misaligned: Inst_Addr[1:0] != 0.
  - Out of range: Inst_Addr > DEPTH_BYTES-4. The comparison is done at full ADDR_W width, with no wrap-around of A+3.
  - On fault: Fault=1 and Instruction=32'h00000013. Otherwise Fault=0 and Instruction is the little-endian word.
- Fetch_Count increments by 1 on every accepted request, including faulting ones. It wraps modulo 2^CNT_W.
- Rsp_Valid is low in EMPTY. In that state Instruction and Fault hold their last values and are don't-care to the consumer.
- Reset asserted mid-transaction: any pending response is discarded immediately and the outputs take their reset values.
- The memory read uses the array contents at the clock edge of acceptance. Loads and fetch acceptance never overlap, because Req_Ready is low during Load_En.

Optional Feature:
Macro INST_MEM_HALFALIGN_EN.
- Defined (for RVC support): only Inst_Addr[0] != 0 counts as misaligned. Halfword-aligned fetches (Inst_Addr[1:0]==2'b10) return 4 bytes from A to A+3, subject to the same range check.
- Not defined: any nonzero Inst_Addr[1:0] faults.

Test Plan:
- Load bytes 83,34,85,02 to addresses 0..3, then request Inst_Addr=0 -> next cycle Rsp_Valid=1, Instruction=32'h02853483, Fault=0, Fetch_Count=1.
- Hold Rsp_Ready=0 for 3 cycles after the response while Req_Valid=1 -> Req_Ready=0 and Instruction stays stable. Raise Rsp_Ready -> the next response follows on the next cycle.
- Stream requests to 0,4,8,12 with Rsp_Ready=1 (bytes loaded to form 02853483, 009A84B3, 00148493, 02953423) -> four consecutive responses in order, no bubbles, Fetch_Count=4.
- Request Inst_Addr=2 -> Fault=1 and Instruction=32'h00000013 without the macro. With INST_MEM_HALFALIGN_EN, Fault=0 and Instruction={A5,A4,A3,A2}.
- Request Inst_Addr=DEPTH_BYTES-4 -> Fault=0. Request Inst_Addr=DEPTH_BYTES -> Fault=1. Request Inst_Addr=64'hFFFF_FFFF_FFFF_FFFC -> Fault=1 (no wrap).
- Assert Load_En together with Req_Valid -> Req_Ready=0 and the write completes. Pulse reset_n low while in FULL -> Rsp_Valid=0 and Fetch_Count=0 immediately, and memory contents are retained.

Source files
------------

// File: rtl/inst_mem_fetch_unit.sv
// Byte-addressed little-endian instruction RAM with a byte loader port and a
// one-deep registered fetch response. Define INST_MEM_HALFALIGN_EN to allow halfword-aligned fetches.
module inst_mem_fetch_unit #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Load_En,
    input  logic [ADDR_W-1:0] Load_Addr,
    input  logic [7:0]        Load_Data,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic [ADDR_W-1:0] Inst_Addr,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [31:0]       Instruction,
    output logic              Fault,
    output logic [CNT_W-1:0]  Fetch_Count
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR     = ADDR_W'(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [31:0]       NOP            = 32'h0000_0013;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mem_q [DEPTH_BYTES];

    logic             accept;
    logic             misaligned;
    logic             out_of_range;
    logic [AW-1:0]    rd_idx;
    logic [31:0]      rd_word;

    // Memory is deliberately not reset; loader writes past the end are dropped.
    always_ff @(posedge clk) begin
        if (Load_En && (Load_Addr < DEPTH_ADDR)) begin
            mem_q[Load_Addr[AW-1:0]] <= Load_Data;
        end
    end

    assign Req_Ready = ((state_q == EMPTY) || Rsp_Ready) && !Load_En;
    assign accept    = Req_Valid && Req_Ready;

`ifdef INST_MEM_HALFALIGN_EN
    assign misaligned = Inst_Addr[0];
`else
    assign misaligned = (Inst_Addr[1:0] != 2'b00);
`endif
    // Full-width compare so addresses near 2^ADDR_W never wrap into range.
    assign out_of_range = (Inst_Addr > LAST_WORD_ADDR);

    assign rd_idx  = Inst_Addr[AW-1:0];
    assign rd_word = {mem_q[rd_idx + AW'(3)], mem_q[rd_idx + AW'(2)],
                      mem_q[rd_idx + AW'(1)], mem_q[rd_idx]};

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = FULL;
            cnt_d   = cnt_q + CNT_W'(1);
            if (misaligned || out_of_range) begin
                instr_d = NOP;
                fault_d = 1'b1;
            end else begin
                instr_d = rd_word;
                fault_d = 1'b0;
            end
        end else if ((state_q == FULL) && Rsp_Ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            instr_q <= NOP;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Rsp_Valid   = (state_q == FULL);
    assign Instruction = instr_q;
    assign Fault       = fault_q;
    assign Fetch_Count = cnt_q;

endmodule

// File: tb/tb_inst_mem_fetch_unit.sv
// Bench for inst_mem_fetch_unit: directed plan items plus a randomized run,
// all checked every cycle against a queue-based reference model.
module tb_inst_mem_fetch_unit;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              Load_En = 1'b0;
    logic [ADDR_W-1:0] Load_Addr = '0;
    logic [7:0]        Load_Data = '0;
    logic              Req_Valid = 1'b0;
    logic              Req_Ready;
    logic [ADDR_W-1:0] Inst_Addr = '0;
    logic              Rsp_Valid;
    logic              Rsp_Ready = 1'b0;
    logic [31:0]       Instruction;
    logic              Fault;
    logic [CNT_W-1:0]  Fetch_Count;

    int checks = 0;
    int errors = 0;

    inst_mem_fetch_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .Load_En(Load_En), .Load_Addr(Load_Addr), .Load_Data(Load_Data),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Inst_Addr(Inst_Addr),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
        .Instruction(Instruction), .Fault(Fault), .Fetch_Count(Fetch_Count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]       mem_m [DEPTH];
    logic [32:0]      exp_q [$];          // {fault, instruction} awaiting consumption
    logic [32:0]      m_last = {1'b0, NOP};
    logic [CNT_W-1:0] m_cnt = '0;

    function automatic logic [32:0] model_rsp(input logic [ADDR_W-1:0] a);
        logic bad;
        int   i;
`ifdef INST_MEM_HALFALIGN_EN
        bad = a[0];
`else
        bad = (a % 4) != 0;
`endif
        if (a > ADDR_W'(DEPTH - 4)) bad = 1'b1;
        if (bad) return {1'b1, NOP};
        i = int'(a);
        return {1'b0, mem_m[i+3], mem_m[i+2], mem_m[i+1], mem_m[i]};
    endfunction

    function automatic logic model_ready();
        return ((exp_q.size() == 0) || Rsp_Ready) && !Load_En;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_last = {1'b0, NOP};
            m_cnt  = '0;
        end else begin
            logic acc;
            acc = Req_Valid && model_ready();
            if (exp_q.size() > 0 && Rsp_Ready) void'(exp_q.pop_front());
            if (acc) begin
                m_last = model_rsp(Inst_Addr);
                exp_q.push_back(m_last);
                m_cnt = m_cnt + 1;
            end
            if (Load_En && Load_Addr < ADDR_W'(DEPTH)) mem_m[int'(Load_Addr)] = Load_Data;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("rsp_valid",   64'(Rsp_Valid),   64'(exp_q.size() > 0));
        chk("req_ready",   64'(Req_Ready),   64'(model_ready()));
        chk("fetch_count", 64'(Fetch_Count), 64'(m_cnt));
        chk("instruction", 64'(Instruction), 64'(m_last[31:0]));
        chk("fault",       64'(Fault),       64'(m_last[32]));
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic le, input logic [ADDR_W-1:0] la, input logic [7:0] ld,
                         input logic rv, input logic [ADDR_W-1:0] ia, input logic rr);
        Load_En = le; Load_Addr = la; Load_Data = ld;
        Req_Valid = rv; Inst_Addr = ia; Rsp_Ready = rr;
        @(negedge clk); #1;
    endtask

    task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        drive(1'b1, a, d, 1'b0, '0, 1'b1);
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        drive(1'b0, '0, '0, 1'b1, a, 1'b1);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    logic [31:0] prog [4] = '{32'h0285_3483, 32'h009A_84B3, 32'h0014_8493, 32'h0295_3423};

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk); #1;

        // fill the whole array so the model knows every byte
        for (int a = 0; a < DEPTH; a++) begin
            if (a < 16) begin
                w = prog[a/4];
                load_byte(ADDR_W'(a), w[8*(a%4) +: 8]);
            end else begin
                load_byte(ADDR_W'(a), 8'($urandom_range(0, 255)));
            end
        end
        idle();

        fetch('0);
        chk("t1_valid", 64'(Rsp_Valid), 64'd1);
        chk("t1_instr", 64'(Instruction), 64'h0285_3483);
        chk("t1_fault", 64'(Fault), 64'd0);
        chk("t1_count", 64'(Fetch_Count), 64'd1);

        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, 64'd4, 1'b0);
            chk("bp_ready", 64'(Req_Ready), 64'd0);
            chk("bp_instr", 64'(Instruction), 64'h0285_3483);
        end
        fetch(64'd4);
        chk("bp_next_instr", 64'(Instruction), 64'h009A_84B3);
        chk("bp_next_count", 64'(Fetch_Count), 64'd2);

        for (int k = 0; k < 4; k++) begin
            fetch(ADDR_W'(4*k));
            chk("stream_valid", 64'(Rsp_Valid), 64'd1);
            chk("stream_instr", 64'(Instruction), 64'(prog[k]));
        end
        chk("stream_count", 64'(Fetch_Count), 64'd6);

        fetch(64'd2);
`ifdef INST_MEM_HALFALIGN_EN
        chk("half_fault", 64'(Fault), 64'd0);
        chk("half_instr", 64'(Instruction), 64'h84B3_0285);
`else
        chk("half_fault", 64'(Fault), 64'd1);
        chk("half_instr", 64'(Instruction), 64'(NOP));
`endif
        fetch(ADDR_W'(DEPTH - 4));
        chk("last_word_fault", 64'(Fault), 64'd0);
        fetch(ADDR_W'(DEPTH));
        chk("depth_fault", 64'(Fault), 64'd1);
        chk("depth_instr", 64'(Instruction), 64'(NOP));
        fetch(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_fault", 64'(Fault), 64'd1);

        // loader write collides with a fetch request
        Load_En = 1'b1; Load_Addr = 64'd100; Load_Data = 8'h5A;
        Req_Valid = 1'b1; Inst_Addr = 64'd100; Rsp_Ready = 1'b1;
        #1 chk("load_stall_ready", 64'(Req_Ready), 64'd0);
        @(negedge clk); #1;
        fetch(64'd100);
        chk("load_written", 64'(Instruction[7:0]), 64'h5A);

        // asynchronous reset while a response is pending
        fetch('0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(Rsp_Valid), 64'd0);
        chk("rst_count", 64'(Fetch_Count), 64'd0);
        chk("rst_instr", 64'(Instruction), 64'(NOP));
        @(negedge clk); #1 reset_n = 1'b1;
        @(negedge clk); #1;
        fetch('0);
        chk("retained_instr", 64'(Instruction), 64'h0285_3483);
        chk("retained_count", 64'(Fetch_Count), 64'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [ADDR_W-1:0] ia;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ia = ADDR_W'($urandom_range(0, DEPTH/4 - 1) * 4);
                6:       ia = ADDR_W'($urandom_range(0, DEPTH + 6));
                7:       ia = ADDR_W'(DEPTH - 4 + $urandom_range(0, 8));
                8:       ia = 64'hFFFF_FFFF_FFFF_FFF0 + ADDR_W'($urandom_range(0, 15));
                default: ia = {$urandom, $urandom};
            endcase
            drive($urandom_range(0, 9) == 0, ADDR_W'($urandom_range(0, DEPTH + 80)),
                  8'($urandom_range(0, 255)), $urandom_range(0, 9) < 7, ia,
                  $urandom_range(0, 9) < 7);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
